// File: rtl/mux8way16_pkg.sv
// mux8way16_pkg
//   Shared types and select codes for the 8-way word multiplexer.
//   WIDTH   : default data word width (16)
//   word_t  : one data word at the default width
//   sel_t   : 3-bit select code
//   SEL_A .. SEL_Z : select code for each data input
package mux8way16_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [2:0]       sel_t;

  localparam sel_t SEL_A = 3'd0;
  localparam sel_t SEL_B = 3'd1;
  localparam sel_t SEL_C = 3'd2;
  localparam sel_t SEL_D = 3'd3;
  localparam sel_t SEL_W = 3'd4;
  localparam sel_t SEL_X = 3'd5;
  localparam sel_t SEL_Y = 3'd6;
  localparam sel_t SEL_Z = 3'd7;

endpackage

// File: rtl/mux4way16.sv
// mux4way16
//   Combinational 4-way word multiplexer, one half of mux8way16.
//   Ports:
//     a, b, c, d : data inputs, picked by sel = 0, 1, 2, 3
//     sel        : 2-bit select
//     y          : selected word, passed bit-exact
module mux4way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Ternaries rather than a case statement so an unknown select
  // propagates as X in simulation instead of falling into a default arm.
  assign y = sel[1] ? (sel[0] ? d : c)
                    : (sel[0] ? b : a);

endmodule

// File: rtl/mux8way16.sv
// mux8way16
//   8-input word multiplexer with a registered output (1-cycle latency).
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     rst    : asynchronous, active-high reset; clears OUT (and parity)
//     A,B,C,D: data inputs selected by s = 0..3
//     W,X,Y,Z: data inputs selected by s = 4..7
//     s      : 3-bit select, a new one is taken every cycle
//     OUT    : registered selected word
//     parity : XOR-reduce of OUT, registered alongside it
//              (present only when MUX8WAY16_PARITY_EN is defined)
//   Configuration macro: MUX8WAY16_PARITY_EN
module mux8way16
  import mux8way16_pkg::*;
#(
  parameter int WIDTH = mux8way16_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  input  sel_t             s,
  output logic [WIDTH-1:0] OUT
`ifdef MUX8WAY16_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] lo_word;
  logic [WIDTH-1:0] hi_word;
  logic [WIDTH-1:0] sel_word;

  mux4way16 #(.WIDTH(WIDTH)) lo (
    .a   (A),
    .b   (B),
    .c   (C),
    .d   (D),
    .sel (s[1:0]),
    .y   (lo_word)
  );

  mux4way16 #(.WIDTH(WIDTH)) hi (
    .a   (W),
    .b   (X),
    .c   (Y),
    .d   (Z),
    .sel (s[1:0]),
    .y   (hi_word)
  );

  assign sel_word = s[2] ? hi_word : lo_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT <= '0;
    end else begin
      OUT <= sel_word;
    end
  end

`ifdef MUX8WAY16_PARITY_EN
  // Parity is computed from the word being loaded, not from OUT, so it
  // lands in the same cycle as the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= ^sel_word;
    end
  end
`endif

endmodule

// File: tb/tb_mux8way16.sv
module tb_mux8way16;

  logic        clk;
  logic        rst;
  logic [15:0] din [8];
  logic [2:0]  s;
  logic [15:0] out;
`ifdef MUX8WAY16_PARITY_EN
  logic        parity;
`endif

  int n_checks;
  int n_pass;

  mux8way16 dut (
    .clk    (clk),
    .rst    (rst),
    .A      (din[0]),
    .B      (din[1]),
    .C      (din[2]),
    .D      (din[3]),
    .W      (din[4]),
    .X      (din[5]),
    .Y      (din[6]),
    .Z      (din[7]),
    .s      (s),
    .OUT    (out)
`ifdef MUX8WAY16_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Reference: the word addressed by s at the edge appears one cycle later.
  task automatic tick_check(input string tag);
    logic [15:0] exp;
    exp = din[s];
    @(posedge clk);
    #1;
    check(tag, out, exp);
`ifdef MUX8WAY16_PARITY_EN
    check({tag, "_par"}, {15'd0, parity}, {15'd0, 1'($countones(exp) % 2)});
`endif
  endtask

  task automatic check_zero(input string tag);
    check(tag, out, 16'h0000);
`ifdef MUX8WAY16_PARITY_EN
    check({tag, "_par"}, {15'd0, parity}, 16'h0000);
`endif
  endtask

  initial begin
    logic [15:0] c_hold;
    logic [15:0] sweep [8];
    n_checks = 0;
    n_pass   = 0;

    // Reset applied with no clock edge yet: OUT must already be zero.
    rst = 1'b1;
    s   = 3'd3;
    for (int i = 0; i < 8; i++) din[i] = 16'h1111 * 16'(i + 1);
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held_edge");
    @(negedge clk);
    rst = 1'b0;

    // Directed sweep, s = 0..7 one per cycle.
    sweep[0] = 16'd3;  sweep[1] = 16'd9;  sweep[2] = 16'd17; sweep[3] = 16'd5;
    sweep[4] = 16'd11; sweep[5] = 16'd2;  sweep[6] = 16'd24; sweep[7] = 16'd8;
    for (int i = 0; i < 8; i++) din[i] = sweep[i];
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      tick_check($sformatf("sweep_s%0d", i));
      check($sformatf("sweep_val%0d", i), out, sweep[i]);
    end

    // Extremes: s alternating 7 and 0.
    din[7] = 16'hFFFF;
    din[0] = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 0) ? 3'd7 : 3'd0;
      tick_check($sformatf("extreme_%0d", i));
    end

    // Reset between edges while OUT=24, then recover on s=1.
    din[6] = 16'd24;
    s = 3'd6;
    tick_check("pre_mid_reset");
    check("pre_mid_reset_val", out, 16'd24);
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_reset_async");
    @(negedge clk);
    rst = 1'b0;
    din[1] = 16'd9;
    s = 3'd1;
    tick_check("post_reset");
    check("post_reset_val", out, 16'd9);

    // Reset held across an edge wins over the data path.
    s = 3'd7;
    din[7] = 16'hBEEF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_vs_edge");
    @(negedge clk);
    rst = 1'b0;

`ifdef MUX8WAY16_PARITY_EN
    din[4] = 16'h0007;
    s = 3'd4;
    tick_check("par_odd");
    check("par_odd_bit", {15'd0, parity}, 16'd1);
    din[2] = 16'h0003;
    s = 3'd2;
    tick_check("par_even");
    check("par_even_bit", {15'd0, parity}, 16'd0);
`endif

    // Isolation: s fixed at 2, everything but C churns.
    c_hold = 16'h5A5A;
    din[2] = c_hold;
    s = 3'd2;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++)
        if (k != 2) din[k] = 16'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("isolation_%0d", i), out, c_hold);
    end

    // Randomized traffic against the array model.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) din[k] = 16'($urandom);
      s = 3'($urandom_range(0, 7));
      tick_check($sformatf("rand_%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
